// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader: streams a length-prefixed word image into instruction memory
// while holding the core in reset. Optional: IMEM_LOADER_CHECKSUM_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    output logic        o_im_wr_en,
    output logic [31:0] o_im_wr_addr,
    output logic [31:0] o_im_wr_data,
    output logic        o_core_hold,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_load_err,
    output logic [15:0] o_words_loaded
);

    localparam logic [16:0] c_MAX_WORDS = 17'(MAX_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERROR, S_CHK
    } state_t;
    localparam state_t c_END_STATE = S_CHK;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERROR
    } state_t;
    localparam state_t c_END_STATE = S_DONE;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_len_hi;
    logic [15:0] r_len;
    logic [15:0] r_words;
    logic [1:0]  r_byte_cnt;
    logic [31:0] r_word;
    logic        w_accept;
    logic        w_restart;
    logic [15:0] w_len_cat;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  r_chk;
`endif

    assign w_len_cat = {r_len_hi, i_byte};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        o_byte_ready   = 1'b0;
        o_im_wr_en     = 1'b0;
        o_im_wr_addr   = 32'h0;
        o_im_wr_data   = 32'h0;
        o_busy         = 1'b0;
        o_core_hold    = 1'b1;
        o_done         = 1'b0;
        o_load_err     = 1'b0;
        w_restart      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                o_core_hold = (r_state != S_DONE);
                o_done      = (r_state == S_DONE);
                o_load_err  = (r_state == S_ERROR);
                if (i_start) begin
                    w_restart = 1'b1;
                    w_next    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
                if (i_byte_valid) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
                if (i_byte_valid) begin
                    if (w_len_cat == 16'd0)                   w_next = c_END_STATE;
                    else if ({1'b0, w_len_cat} > c_MAX_WORDS) w_next = S_ERROR;
                    else                                      w_next = S_DATA;
                end
            end
            S_DATA: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
                if (i_byte_valid && (r_byte_cnt == 2'd3)) w_next = S_WRITE;
            end
            S_WRITE: begin
                o_busy       = 1'b1;
                o_im_wr_en   = 1'b1;
                o_im_wr_addr = BASE_ADDR + {14'd0, r_words, 2'b00};
                o_im_wr_data = r_word;
                w_next       = ((r_words + 16'd1) == r_len) ? c_END_STATE : S_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
                if (i_byte_valid) w_next = (i_byte == r_chk) ? S_DONE : S_ERROR;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept = i_byte_valid & o_byte_ready;

    // Datapath: header capture, big-endian word assembly and word count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len_hi   <= 8'h0;
            r_len      <= 16'h0;
            r_words    <= 16'h0;
            r_byte_cnt <= 2'd0;
            r_word     <= 32'h0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_chk      <= 8'h0;
`endif
        end else if (w_restart) begin
            r_words    <= 16'h0;
            r_byte_cnt <= 2'd0;
            r_word     <= 32'h0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_chk      <= 8'h0;
`endif
        end else begin
            if (w_accept && (r_state == S_LEN_HI)) r_len_hi <= i_byte;
            if (w_accept && (r_state == S_LEN_LO)) r_len    <= w_len_cat;
            if (w_accept && (r_state == S_DATA)) begin
                r_word     <= {r_word[23:0], i_byte};
                r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_chk      <= r_chk ^ i_byte;
`endif
            end
            if (r_state == S_WRITE) r_words <= r_words + 16'd1;
        end
    end

    assign o_words_loaded = r_words;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// tb_imem_loader: directed streams with a write scoreboard and status checks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [7:0]  i_byte;
    logic        i_byte_valid;
    logic        o_byte_ready;
    logic        o_im_wr_en;
    logic [31:0] o_im_wr_addr;
    logic [31:0] o_im_wr_data;
    logic        o_core_hold;
    logic        o_busy;
    logic        o_done;
    logic        o_load_err;
    logic [15:0] o_words_loaded;

    int          n_checks = 0;
    int          n_errors = 0;
    int          wr_cnt   = 0;
    bit          g_toggle = 1'b0;
    logic [63:0] exp_q[$];

    imem_loader #(
        .BASE_ADDR (32'h0000_0000),
        .MAX_WORDS (4)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (i_start),
        .i_byte         (i_byte),
        .i_byte_valid   (i_byte_valid),
        .o_byte_ready   (o_byte_ready),
        .o_im_wr_en     (o_im_wr_en),
        .o_im_wr_addr   (o_im_wr_addr),
        .o_im_wr_data   (o_im_wr_data),
        .o_core_hold    (o_core_hold),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_load_err     (o_load_err),
        .o_words_loaded (o_words_loaded)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe pops one expected (addr, data) pair.
    always @(negedge clk) begin
        if (o_im_wr_en === 1'b1) begin
            logic [63:0] e;
            wr_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h expected no write",
                         o_im_wr_addr, o_im_wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({o_im_wr_addr, o_im_wr_data} !== e) begin
                    n_errors++;
                    $display("FAIL write: got addr=%h data=%h expected addr=%h data=%h",
                             o_im_wr_addr, o_im_wr_data, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        i_byte       = b;
        i_byte_valid = 1'b1;
        while (o_byte_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_checks++;
            n_errors++;
            $display("FAIL byte_timeout: got ready=%b expected ready=1", o_byte_ready);
        end
        @(negedge clk);
        i_byte_valid = 1'b0;
        if (g_toggle) @(negedge clk);
    endtask

    task automatic send_len(input logic [15:0] n);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic send_chk(input logic [7:0] c);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(c);
`else
        if (c === 8'hxx) i_byte = 8'h00;
`endif
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic done, input logic err,
                                input logic hold, input logic [15:0] words);
        repeat (3) @(negedge clk);
        check({tag, "_done"},  {31'd0, o_done},      {31'd0, done});
        check({tag, "_err"},   {31'd0, o_load_err},  {31'd0, err});
        check({tag, "_hold"},  {31'd0, o_core_hold}, {31'd0, hold});
        check({tag, "_busy"},  {31'd0, o_busy},      32'd0);
        check({tag, "_words"}, {16'd0, o_words_loaded}, {16'd0, words});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, o_byte_ready}, 32'd0);
        check({tag, "_wren"},  {31'd0, o_im_wr_en},   32'd0);
        check({tag, "_addr"},  o_im_wr_addr,           32'd0);
        check({tag, "_data"},  o_im_wr_data,           32'd0);
        check({tag, "_hold"},  {31'd0, o_core_hold},  32'd1);
        check({tag, "_busy"},  {31'd0, o_busy},       32'd0);
        check({tag, "_done"},  {31'd0, o_done},       32'd0);
        check({tag, "_err"},   {31'd0, o_load_err},   32'd0);
        check({tag, "_words"}, {16'd0, o_words_loaded}, 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        i_start      = 1'b0;
        i_byte       = 8'h00;
        i_byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_start_hold", {31'd0, o_core_hold}, 32'd1);

        // Two-word load, back-to-back bytes
        wr_cnt = 0;
        expect_write(32'h0, 32'h2008_0005);
        expect_write(32'h4, 32'hAC08_0000);
        pulse_start();
        check("start_busy", {31'd0, o_busy}, 32'd1);
        send_len(16'd2);
        send_word(32'h2008_0005);
        send_word(32'hAC08_0000);
        send_chk(8'h89);
        check_status("two_word", 1'b1, 1'b0, 1'b0, 16'd2);
        check("two_word_wrcnt", wr_cnt, 32'd2);

        // Same stream with ByteValid toggling
        wr_cnt   = 0;
        g_toggle = 1'b1;
        expect_write(32'h0, 32'h2008_0005);
        expect_write(32'h4, 32'hAC08_0000);
        pulse_start();
        check("restart_clears_done", {31'd0, o_done}, 32'd0);
        send_len(16'd2);
        send_word(32'h2008_0005);
        send_word(32'hAC08_0000);
        send_chk(8'h89);
        g_toggle = 1'b0;
        check_status("toggle", 1'b1, 1'b0, 1'b0, 16'd2);
        check("toggle_wrcnt", wr_cnt, 32'd2);

        // Length above MAX_WORDS
        wr_cnt = 0;
        pulse_start();
        send_len(16'd5);
        check_status("too_long", 1'b0, 1'b1, 1'b1, 16'd0);
        check("too_long_wrcnt", wr_cnt, 32'd0);

        // Good load after error, with a long mid-header and mid-word stall
        wr_cnt = 0;
        expect_write(32'h0, 32'h0102_0304);
        pulse_start();
        send_byte(8'h00);
        repeat (10) @(negedge clk);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h02);
        repeat (12) @(negedge clk);
        send_byte(8'h03);
        send_byte(8'h04);
        send_chk(8'h04);
        check_status("recover", 1'b1, 1'b0, 1'b0, 16'd1);
        check("recover_wrcnt", wr_cnt, 32'd1);

        // Zero-length load
        wr_cnt = 0;
        pulse_start();
        send_len(16'd0);
        send_chk(8'h00);
        check_status("zero_len", 1'b1, 1'b0, 1'b0, 16'd0);
        check("zero_len_wrcnt", wr_cnt, 32'd0);

        // Start pulse mid-word is ignored
        wr_cnt = 0;
        expect_write(32'h0, 32'hDEAD_BEEF);
        pulse_start();
        send_len(16'd1);
        send_byte(8'hDE);
        pulse_start();
        repeat (4) @(negedge clk);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        send_chk(8'h22);
        check_status("start_ignored", 1'b1, 1'b0, 1'b0, 16'd1);

        // Reset mid-DATA, then a fresh single-word load
        wr_cnt = 0;
        pulse_start();
        send_len(16'd1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_write(32'h0, 32'h1122_3344);
        pulse_start();
        send_len(16'd1);
        send_word(32'h1122_3344);
        send_chk(8'h44);
        check_status("after_rst", 1'b1, 1'b0, 1'b0, 16'd1);
        check("after_rst_wrcnt", wr_cnt, 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        expect_write(32'h0, 32'h1234_5678);
        pulse_start();
        send_len(16'd1);
        send_word(32'h1234_5678);
        send_byte(8'h08);
        check_status("chk_good", 1'b1, 1'b0, 1'b0, 16'd1);

        wr_cnt = 0;
        expect_write(32'h0, 32'h1234_5678);
        pulse_start();
        send_len(16'd1);
        send_word(32'h1234_5678);
        send_byte(8'h09);
        check_status("chk_bad", 1'b0, 1'b1, 1'b1, 16'd1);
        check("chk_bad_wrcnt", wr_cnt, 32'd1);
`endif

        repeat (2) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first instruction word written.
REQ-002 Parameter MAX_WORDS, default 256, largest accepted word count; legal range 1..65535.
REQ-003 Clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Start  input  1  single-cycle load request.
REQ-006 ByteIn  input  8  incoming load-stream byte.
REQ-007 ByteValid  input  1  ByteIn holds a valid byte.
REQ-008 ByteReady  output  1  loader accepts ByteIn this cycle.
REQ-009 ImWrEn  output  1  instruction-memory write strobe.
REQ-010 ImWrAddr  output  32  instruction-memory byte address, always word aligned.
REQ-011 ImWrData  output  32  instruction word to write.
REQ-012 CoreHold  output  1  1 = MIPS core held in reset; 0 = core free to fetch.
REQ-013 Busy  output  1  load in progress.
REQ-014 Done  output  1  last load completed without error.
REQ-015 LoadErr  output  1  last load aborted.
REQ-016 WordsLoaded  output  16  count of words written in the current or last load.

Function
REQ-017 A byte SHALL transfer only on a rising edge where ByteValid=1 and ByteReady=1.
REQ-018 Stream format: length high byte, length low byte (N, big-endian), then N words at 4 bytes each, most significant byte first.
REQ-019 States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR.
REQ-020 IDLE/DONE/ERROR: Start=1 -> LEN_HI, clearing WordsLoaded, Done and LoadErr and asserting CoreHold. Start is ignored in all other states.
REQ-021 LEN_HI -> LEN_LO on byte accept; LEN_LO -> DATA on byte accept.
REQ-022 On exit from LEN_LO: N=0 -> DONE; N>MAX_WORDS -> ERROR.
REQ-023 DATA: the 4th accepted byte of a word -> WRITE.
REQ-024 WRITE lasts exactly one cycle, with ImWrEn=1, ImWrAddr=BASE_ADDR+4*WordsLoaded and ImWrData=assembled word. WordsLoaded SHALL increment at the end of that cycle.
REQ-025 WRITE exits to DONE if the incremented WordsLoaded equals N; otherwise it exits to DATA.
REQ-026 ByteReady=1 only in LEN_HI, LEN_LO and DATA, so back-to-back bytes sustain 1 word per 5 cycles.
REQ-027 ImWrEn=0 in every state except WRITE.
REQ-028 ImWrAddr arithmetic is modulo 2^32; wrap-around is permitted and not flagged.
REQ-029 Busy=1 in LEN_HI, LEN_LO, DATA and WRITE.
REQ-030 CoreHold=0 only in DONE.
REQ-031 Done=1 only in DONE; LoadErr=1 only in ERROR.
REQ-032 ERROR holds CoreHold=1 until the next Start or reset.
REQ-033 Stalls (ByteValid=0) of any length mid-word or mid-header SHALL preserve all partial state.

Reset
REQ-034 Reset=0 SHALL immediately force IDLE, ByteReady=0, ImWrEn=0, ImWrAddr=0, ImWrData=0, CoreHold=1, Busy=0, Done=0, LoadErr=0 and WordsLoaded=0, and clear the byte counter and assembly register.
REQ-035 Reset asserted mid-load SHALL abandon the load; words already written remain in memory, and no partial word is written.
REQ-036 Leaving reset SHALL take effect on the first rising Clk edge with Reset=1; no Start is implied.

Configuration
REQ-037 With IMEM_LOADER_CHECKSUM_EN defined, an extra state CHK follows the last WRITE (or LEN_LO when N=0), with ByteReady=1.
REQ-038 In CHK, one byte is accepted and compared with the XOR of all data bytes (8'h00 when N=0): match -> DONE, mismatch -> ERROR.
REQ-039 Without IMEM_LOADER_CHECKSUM_EN, CHK SHALL not exist and the stream has no checksum byte.

Verification
REQ-040 Reset mid-DATA after 2 bytes -> outputs at reset values immediately. A new Start plus N=1 stream then writes the correct fresh word, with no stale bytes.
REQ-041 BASE_ADDR=0, Start, stream 00 02 | 20 08 00 05 | AC 08 00 00 -> two writes: (0x0, 0x20080005) then (0x4, 0xAC080000). Done=1, CoreHold=0, WordsLoaded=2.
REQ-042 Same stream with ByteValid toggled 1/0 every cycle -> identical writes, and ImWrEn high exactly 2 cycles.
REQ-043 MAX_WORDS=4, stream 00 05 -> ERROR, LoadErr=1, CoreHold=1, no ImWrEn. A following Start with a good stream -> DONE.
REQ-044 Stream 00 00 -> DONE with WordsLoaded=0 and no writes. With IMEM_LOADER_CHECKSUM_EN, a checksum byte 00 is required first.
REQ-045 IMEM_LOADER_CHECKSUM_EN: stream 00 01 12 34 56 78 + checksum 0x08 -> DONE. Checksum 0x09 -> ERROR after the word is written.
